// File: rtl/l2_line_serializer.sv
// l2_line_serializer
//   Sits below the L2 memory port. A full-line read or write request is turned
//   into a single AXI4 INCR burst of BEATS = LINE_BITS/BUS_BITS narrow beats.
//   Read beats are reassembled into a line buffer and handed back to the L2
//   with a one-cycle response pulse. One transaction is in flight at a time.
//
//   Optional feature macro: L2_SER_ZERO_STRB_SKIP_EN
//     defined   - a write with all-zero byte strobes skips the bus entirely and
//                 responds one cycle after accept with fault=0.
//     undefined - every write issues the full burst.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_req_* / o_req_ready        line request from the L2 (valid/ready)
//   o_resp_valid/_rdata/_fault   single-cycle response to the L2
//   o_ar_* / i_ar_ready          AXI read address channel
//   i_r_* / o_r_ready            AXI read data channel
//   o_aw_* / i_aw_ready          AXI write address channel
//   o_w_* / i_w_ready            AXI write data channel
//   i_b_* / o_b_ready            AXI write response channel

module l2_line_serializer #(
  parameter int ADDR_BITS = 48,
  parameter int LINE_BITS = 256,
  parameter int BUS_BITS  = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDR_BITS-1:0]     i_req_addr,
  input  logic [LINE_BITS-1:0]     i_req_wdata,
  input  logic [LINE_BITS/8-1:0]   i_req_wstrb,
  output logic                     o_resp_valid,
  output logic [LINE_BITS-1:0]     o_resp_rdata,
  output logic                     o_resp_fault,
  output logic                     o_ar_valid,
  input  logic                     i_ar_ready,
  output logic [ADDR_BITS-1:0]     o_ar_addr,
  output logic [7:0]               o_ar_len,
  input  logic                     i_r_valid,
  output logic                     o_r_ready,
  input  logic [BUS_BITS-1:0]      i_r_data,
  input  logic [1:0]               i_r_resp,
  input  logic                     i_r_last,
  output logic                     o_aw_valid,
  input  logic                     i_aw_ready,
  output logic [ADDR_BITS-1:0]     o_aw_addr,
  output logic [7:0]               o_aw_len,
  output logic                     o_w_valid,
  input  logic                     i_w_ready,
  output logic [BUS_BITS-1:0]      o_w_data,
  output logic [BUS_BITS/8-1:0]    o_w_strb,
  output logic                     o_w_last,
  input  logic                     i_b_valid,
  output logic                     o_b_ready,
  input  logic [1:0]               i_b_resp
);

  localparam int BEATS    = LINE_BITS / BUS_BITS;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int STRB_W   = BUS_BITS / 8;
  localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(BEATS - 1);
  localparam logic [7:0]           BURST_LEN  = 8'(BEATS - 1);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    ~((ADDR_BITS'(1) << OFF_BITS) - ADDR_BITS'(1));

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [LINE_BITS-1:0]   wdata_q;
  logic [LINE_BITS/8-1:0] wstrb_q;
  logic [LINE_BITS-1:0]   line_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   fault_q;

  logic zeroStrbSkip;
  logic onLastBeat;
  logic unused_resp;

  // Only bit 1 of an AXI response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign unused_resp = i_r_resp[0] ^ i_b_resp[0];
  assign onLastBeat  = (cnt_q == LAST_CNT);

`ifdef L2_SER_ZERO_STRB_SKIP_EN
  // A write that touches no byte has nothing to put on the bus.
  assign zeroStrbSkip = i_req_write && (i_req_wstrb == '0);
`else
  assign zeroStrbSkip = 1'b0;
`endif

  // State register; reset aborts any burst without producing a response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state. A read burst ends on whichever comes first: the slave's last
  // flag or the final expected beat, so a misbehaving slave cannot hang us.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_req_valid) state_d = zeroStrbSkip ? RESP : (i_req_write ? AW : AR);
      AR:   if (i_ar_ready) state_d = R;
      R:    if (i_r_valid && (i_r_last || onLastBeat)) state_d = RESP;
      AW:   if (i_aw_ready) state_d = W;
      W:    if (i_w_ready && onLastBeat) state_d = B;
      B:    if (i_b_valid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from state so every valid stays up until its
  // handshake; ready is also forced low while reset is held.
  always_comb begin
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_rdata = '0;
    o_resp_fault = 1'b0;
    o_ar_valid   = 1'b0;
    o_ar_addr    = '0;
    o_ar_len     = '0;
    o_r_ready    = 1'b0;
    o_aw_valid   = 1'b0;
    o_aw_addr    = '0;
    o_aw_len     = '0;
    o_w_valid    = 1'b0;
    o_w_data     = '0;
    o_w_strb     = '0;
    o_w_last     = 1'b0;
    o_b_ready    = 1'b0;
    case (state_q)
      IDLE: o_req_ready = !i_rst;
      AR: begin
        o_ar_valid = 1'b1;
        o_ar_addr  = addr_q;
        o_ar_len   = BURST_LEN;
      end
      R:  o_r_ready = 1'b1;
      AW: begin
        o_aw_valid = 1'b1;
        o_aw_addr  = addr_q;
        o_aw_len   = BURST_LEN;
      end
      W: begin
        o_w_valid = 1'b1;
        o_w_data  = wdata_q[cnt_q*BUS_BITS +: BUS_BITS];
        o_w_strb  = wstrb_q[cnt_q*STRB_W +: STRB_W];
        o_w_last  = onLastBeat;
      end
      B:  o_b_ready = 1'b1;
      RESP: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = line_q;
        o_resp_fault = fault_q;
      end
      default: ;
    endcase
  end

  // Datapath. A read is faulted if any beat reports an error or if the last
  // flag disagrees with the expected beat count; slices not reached by a short
  // burst keep whatever the buffer already held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_req_valid) begin
          addr_q  <= i_req_addr & ALIGN_MASK;
          wdata_q <= i_req_wdata;
          wstrb_q <= i_req_wstrb;
        end
        R: if (i_r_valid) begin
          line_q[cnt_q*BUS_BITS +: BUS_BITS] <= i_r_data;
          fault_q <= fault_q | i_r_resp[1] | (i_r_last != onLastBeat);
          cnt_q   <= cnt_q + 1'b1;
        end
        W: if (i_w_ready) cnt_q <= cnt_q + 1'b1;
        B: if (i_b_valid) fault_q <= i_b_resp[1];
        RESP: begin
          cnt_q   <= '0;
          fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_line_serializer.sv
// tb_l2_line_serializer
//   Directed bench for l2_line_serializer with the default 256-bit line and
//   64-bit bus (four beats). A zero-wait AXI slave is modelled inline; the
//   expected read line is tracked in lineModel as beats are handed over.
//   Honours L2_SER_ZERO_STRB_SKIP_EN the same way the design does.

module tb_l2_line_serializer;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_req_valid, i_req_write;
  logic [47:0]  i_req_addr;
  logic [255:0] i_req_wdata;
  logic [31:0]  i_req_wstrb;
  logic         o_req_ready, o_resp_valid, o_resp_fault;
  logic [255:0] o_resp_rdata;
  logic         o_ar_valid, i_ar_ready, i_r_valid, o_r_ready, i_r_last;
  logic [47:0]  o_ar_addr, o_aw_addr;
  logic [7:0]   o_ar_len, o_aw_len;
  logic [63:0]  i_r_data, o_w_data;
  logic [1:0]   i_r_resp, i_b_resp;
  logic         o_aw_valid, i_aw_ready, o_w_valid, i_w_ready, o_w_last;
  logic [7:0]   o_w_strb;
  logic         i_b_valid, o_b_ready;

  int total = 0;
  int bad   = 0;
  logic [63:0] lineModel [4];

  l2_line_serializer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_fault(o_resp_fault),
    .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len),
    .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data), .i_r_resp(i_r_resp),
    .i_r_last(i_r_last),
    .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr), .o_aw_len(o_aw_len),
    .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data), .o_w_strb(o_w_strb),
    .o_w_last(o_w_last),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp)
  );

  always #5 i_clk = ~i_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beatData(input logic [7:0] base, input int b);
    logic [7:0] v;
    v = base * 8'(b + 1);
    return {8{v}};
  endfunction

  function automatic logic [255:0] modelLine();
    return {lineModel[3], lineModel[2], lineModel[1], lineModel[0]};
  endfunction

  // Presents one request for a single cycle; returns at the negedge of the
  // first cycle after acceptance.
  task automatic applyStimulus(input logic wr, input logic [47:0] addr,
                               input logic [255:0] wdata, input logic [31:0] wstrb);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_wstrb = wstrb;
    checkOutput("reqReady", 256'(o_req_ready), 256'(1));
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic checkRespOnce();
    @(negedge i_clk);
    checkOutput("respSingle", 256'(o_resp_valid), 256'(0));
  endtask

  task automatic runRead(input logic [47:0] addr, input logic [7:0] base, input int lastBeat,
                         input int errBeat, input int rstBeat, output int lat,
                         output logic [255:0] rd, output logic flt, output bit gotResp);
    int b;
    int cyc;
    b = 0; cyc = 1; gotResp = 0; lat = -1; rd = '0; flt = 1'b0;
    i_ar_ready = 1'b1;
    applyStimulus(1'b0, addr, '0, '0);
    while (cyc < 40 && !gotResp) begin
      if (o_ar_valid) begin
        checkOutput("arAddr", 256'(o_ar_addr), 256'(addr & ~48'h1F));
        checkOutput("arLen", 256'(o_ar_len), 256'(3));
      end
      if (o_resp_valid) begin
        gotResp = 1; lat = cyc; rd = o_resp_rdata; flt = o_resp_fault;
      end else begin
        if (o_r_ready) begin
          if (b == rstBeat) begin
            i_rst = 1'b1;
            #1;
            checkOutput("rstCtl", 256'({o_req_ready, o_ar_valid, o_r_ready, o_aw_valid,
                                        o_w_valid, o_b_ready, o_resp_valid, o_resp_fault}), 256'(0));
            checkOutput("rstData", o_resp_rdata, 256'(0));
            i_r_valid = 1'b0; i_r_last = 1'b0; i_ar_ready = 1'b0;
            return;
          end
          i_r_valid = 1'b1;
          i_r_data  = beatData(base, b);
          i_r_resp  = (b == errBeat) ? 2'b10 : 2'b00;
          i_r_last  = (b == lastBeat);
          lineModel[b] = i_r_data;
          b++;
        end else begin
          i_r_valid = 1'b0;
        end
        @(negedge i_clk);
        cyc++;
      end
    end
    i_r_valid = 1'b0; i_r_last = 1'b0; i_r_resp = 2'b00; i_ar_ready = 1'b0;
    if (gotResp) checkRespOnce();
  endtask

  task automatic runWrite(input logic [255:0] wdata, input logic [31:0] wstrb, input bit toggle,
                          output int lat, output int beats, output bit sawAw,
                          output logic [255:0] rd, output logic flt, output bit gotResp);
    int cyc;
    cyc = 1; beats = 0; sawAw = 0; gotResp = 0; lat = -1; rd = '0; flt = 1'b0;
    i_aw_ready = 1'b1;
    applyStimulus(1'b1, 48'h2000_0008, wdata, wstrb);
    while (cyc < 40 && !gotResp) begin
      if (o_aw_valid) begin
        sawAw = 1;
        checkOutput("awAddr", 256'(o_aw_addr), 256'(48'h2000_0000));
        checkOutput("awLen", 256'(o_aw_len), 256'(3));
      end
      if (o_resp_valid) begin
        gotResp = 1; lat = cyc; rd = o_resp_rdata; flt = o_resp_fault;
      end else begin
        if (o_w_valid) begin
          checkOutput("wData", 256'(o_w_data), 256'(wdata[beats*64 +: 64]));
          checkOutput("wStrb", 256'(o_w_strb), 256'(wstrb[beats*8 +: 8]));
          checkOutput("wLast", 256'(o_w_last), 256'(beats == 3));
          i_w_ready = toggle ? (cyc % 2 == 1) : 1'b1;
          if (i_w_ready) beats++;
        end else begin
          i_w_ready = 1'b0;
        end
        i_b_valid = o_b_ready;
        i_b_resp  = 2'b00;
        @(negedge i_clk);
        cyc++;
      end
    end
    i_w_ready = 1'b0; i_b_valid = 1'b0; i_aw_ready = 1'b0;
    if (gotResp) checkRespOnce();
  endtask

  initial begin
    int lat, beats;
    bit sawAw, got;
    logic [255:0] rd;
    logic flt;

    i_rst = 1'b1;
    i_req_valid = 0; i_req_write = 0; i_req_addr = '0; i_req_wdata = '0; i_req_wstrb = '0;
    i_ar_ready = 0; i_r_valid = 0; i_r_data = '0; i_r_resp = '0; i_r_last = 0;
    i_aw_ready = 0; i_w_ready = 0; i_b_valid = 0; i_b_resp = '0;
    for (int i = 0; i < 4; i++) lineModel[i] = '0;

    repeat (2) @(negedge i_clk);
    checkOutput("resetOut", 256'({o_req_ready, o_ar_valid, o_r_ready, o_aw_valid, o_w_valid,
                                  o_b_ready, o_resp_valid, o_ar_len, o_aw_len}), 256'(0));
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("idleReady", 256'(o_req_ready), 256'(1));

    // Clean read, unaligned address, zero-wait slave.
    runRead(48'h1000_0014, 8'h11, 3, -1, -1, lat, rd, flt, got);
    checkOutput("rd1Seen", 256'(got), 256'(1));
    checkOutput("rd1Lat", 256'(lat), 256'(6));
    checkOutput("rd1Data", rd, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    checkOutput("rd1Fault", 256'(flt), 256'(0));

    // Full write with W ready toggling; response carries current buffer.
    runWrite({32{8'hA5}}, 32'hFFFF_FFFF, 1'b1, lat, beats, sawAw, rd, flt, got);
    checkOutput("wr1Seen", 256'(got), 256'(1));
    checkOutput("wr1Beats", 256'(beats), 256'(4));
    checkOutput("wr1Lat", 256'(lat), 256'(11));
    checkOutput("wr1Fault", 256'(flt), 256'(0));
    checkOutput("wr1Buf", rd, modelLine());

    // Error on beat 1, then a clean read clears the fault.
    runRead(48'h0000_4040, 8'h21, 3, 1, -1, lat, rd, flt, got);
    checkOutput("rdErrSeen", 256'(got), 256'(1));
    checkOutput("rdErrFault", 256'(flt), 256'(1));
    runRead(48'h0000_5000, 8'h03, 3, -1, -1, lat, rd, flt, got);
    checkOutput("rdCleanFault", 256'(flt), 256'(0));
    checkOutput("rdCleanData", rd, modelLine());

    // Early last on beat 1: short burst, upper slices keep previous data.
    runRead(48'h0000_6020, 8'h07, 1, -1, -1, lat, rd, flt, got);
    checkOutput("rdShortLat", 256'(lat), 256'(4));
    checkOutput("rdShortFault", 256'(flt), 256'(1));
    checkOutput("rdShortData", rd, modelLine());

    // All-zero strobes.
    runWrite({32{8'h5A}}, 32'h0, 1'b0, lat, beats, sawAw, rd, flt, got);
    checkOutput("wrZeroSeen", 256'(got), 256'(1));
    checkOutput("wrZeroFault", 256'(flt), 256'(0));
`ifdef L2_SER_ZERO_STRB_SKIP_EN
    checkOutput("wrZeroAw", 256'(sawAw), 256'(0));
    checkOutput("wrZeroBeats", 256'(beats), 256'(0));
    checkOutput("wrZeroLat", 256'(lat), 256'(1));
`else
    checkOutput("wrZeroAw", 256'(sawAw), 256'(1));
    checkOutput("wrZeroBeats", 256'(beats), 256'(4));
    checkOutput("wrZeroLat", 256'(lat), 256'(7));
`endif

    // Reset during R beat 2: no response, then normal operation.
    runRead(48'h0000_7000, 8'h05, 3, -1, 2, lat, rd, flt, got);
    checkOutput("rstNoResp", 256'(got), 256'(0));
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) lineModel[i] = '0;
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("rstQuiet", 256'(o_resp_valid), 256'(0));
    end
    runRead(48'h0000_8000, 8'h09, 3, -1, -1, lat, rd, flt, got);
    checkOutput("rdPostRstLat", 256'(lat), 256'(6));
    checkOutput("rdPostRstData", rd, modelLine());
    checkOutput("rdPostRstFault", 256'(flt), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_line_serializer.md
Name: l2_line_serializer

Overview:
- Downstream neighbour of the L2 cache memory port.
- Takes one full-line read or write request from the L2 and converts it into an AXI4 INCR burst of BEATS narrow beats on the system bus.
- For reads, reassembles the returned beats into a full line and returns it to the L2 with a single-cycle response pulse.
- Handles one transaction at a time; the L2 side never stalls a response.

Parameters:
- ADDR_BITS, 48, request and AXI address width.
- LINE_BITS, 256, cache line width.
- BUS_BITS, 64, AXI data width. BEATS = LINE_BITS/BUS_BITS (4 by default). LINE_BITS must be an integer multiple of BUS_BITS, with BEATS a power of two, at most 256.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  line request valid.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_write  in  1  1=write line, 0=read line.
- i_req_addr  in  ADDR_BITS  request address (any alignment).
- i_req_wdata  in  LINE_BITS  write line data.
- i_req_wstrb  in  LINE_BITS/8  write byte strobes.
- o_resp_valid  out  1  one-cycle response pulse.
- o_resp_rdata  out  LINE_BITS  assembled read line.
- o_resp_fault  out  1  bus error on this transaction; qualified by o_resp_valid.
- o_ar_valid / i_ar_ready  out/in  1  AXI AR handshake.
- o_ar_addr  out  ADDR_BITS  AR address.
- o_ar_len  out  8  AR burst length.
- i_r_valid / o_r_ready  in/out  1  AXI R handshake.
- i_r_data  in  BUS_BITS  R data.
- i_r_resp  in  2  R response.
- i_r_last  in  1  R last beat.
- o_aw_valid / i_aw_ready  out/in  1  AXI AW handshake.
- o_aw_addr  out  ADDR_BITS  AW address.
- o_aw_len  out  8  AW burst length.
- o_w_valid / i_w_ready  out/in  1  AXI W handshake.
- o_w_data  out  BUS_BITS  W data.
- o_w_strb  out  BUS_BITS/8  W strobes.
- o_w_last  out  1  W last beat.
- i_b_valid / o_b_ready  in/out  1  AXI B handshake.
- i_b_resp  in  2  B response.

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0; fault flag 0; line buffer 0. Assertion mid-transaction aborts immediately; no response is issued.
- Request latch: on valid&ready, latch addr aligned down to the line boundary (low log2(LINE_BITS/8) bits cleared), plus wdata, wstrb, write.
- Burst fields: burst type INCR, size log2(BUS_BITS/8), len = BEATS-1. o_ar_len and o_aw_len drive BEATS-1; other AXI fields are outside this block.
- IDLE: o_req_ready=1.
  - Accepted read -> AR.
  - Accepted write -> AW.
- AR: o_ar_valid=1 with the latched addr, starting the cycle after accept. On i_ar_ready -> R.
- R: o_r_ready=1. On each R handshake:
  - i_r_data goes into line slice [cnt*BUS_BITS +: BUS_BITS].
  - fault |= i_r_resp[1].
  - cnt++.
  - Ends when i_r_last=1 or cnt==BEATS-1, whichever comes first -> RESP.
  - last before beat BEATS-1, or beat BEATS-1 without last: fault=1. Unfilled slices keep their previous buffer contents.
- AW: o_aw_valid=1. On i_aw_ready -> W.
- W: o_w_valid=1.
  - o_w_data and o_w_strb = slice cnt of the latched wdata/wstrb.
  - o_w_last = (cnt==BEATS-1).
  - cnt advances on handshake. The last handshake -> B.
  - Data and strobes are held stable while stalled.
- B: o_b_ready=1. On i_b_valid: fault = i_b_resp[1] -> RESP.
- RESP: o_resp_valid=1 for exactly one cycle with rdata (read) or the current buffer (write) plus fault; clear cnt and fault -> IDLE.
- Minimum latency, zero-wait bus: read accept at T0, AR at T1, R beats T2..T(1+BEATS), resp at T(2+BEATS). Write resp at T(3+BEATS).
- Valid stability: o_*_valid never drops before its handshake. Inputs are ignored outside their states.

Optional Feature:
- Macro: L2_SER_ZERO_STRB_SKIP_EN.
- Defined: a write whose i_req_wstrb is all zero generates no AW/W/B traffic. The FSM goes IDLE -> RESP, with o_resp_valid 1 cycle after accept and fault=0.
- Undefined: every write issues a full burst, including all-zero strobes.

Test Plan:
- Read, addr=0x1000_0014, zero-wait slave returns beats 0x11..,0x22..,0x33..,0x44.. with last on beat 3 -> o_ar_addr=0x1000_0000, o_ar_len=3; resp at T6 with rdata {0x44..,0x33..,0x22..,0x11..}; fault=0.
- Write, line 0xA5 pattern, wstrb=all-ones, i_w_ready toggling 1/0 -> exactly 4 W beats, each stable while stalled; o_w_last only on beat 3; one resp after B OKAY.
- Read with i_r_resp=2'b10 on beat 1 -> resp fault=1. A following clean read -> fault=0.
- Read with i_r_last asserted on beat 1 -> resp after 2 beats, fault=1.
- Write with wstrb=0 -> with L2_SER_ZERO_STRB_SKIP_EN: no o_aw_valid, resp 1 cycle after accept. Without the macro: full burst with o_w_strb=0 on every beat.
- i_rst pulsed during R beat 2 -> all outputs 0 within the same cycle, no o_resp_valid; the next request proceeds normally.
